// File: rtl/sim_dpram_asym.sv
// rtl/sim_dpram_asym.sv - narrow-write / wide-read simulation RAM with 1- or 2-cycle read pipeline
// Optional SIM_DPRAM_ASYM_BYPASS_EN selects write-first collision data (default read-first).
module sim_dpram_asym #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int RATIO   = 2,
  parameter int LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we_i,
  input  logic [$clog2(DEPTH)-1:0]         waddr_i,
  input  logic [WIDTH-1:0]                 wdata_i,
  input  logic                             re_i,
  input  logic [$clog2(DEPTH/RATIO)-1:0]   raddr_i,
  input  logic                             sleep_i,
  output logic [RATIO*WIDTH-1:0]           rdata_o,
  output logic                             rvalid_o,
  output logic                             collision_o
);
  localparam int AW  = $clog2(DEPTH);
  localparam int RAW = $clog2(DEPTH/RATIO);
  localparam int LB  = $clog2(RATIO);
  localparam int RW  = RATIO*WIDTH;

  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $error("sim_dpram_asym: LATENCY must be 1 or 2");
  end
  if (RATIO < 1 || RATIO > 16 || (RATIO & (RATIO-1)) != 0 || (DEPTH % RATIO) != 0) begin : g_bad_ratio
    $error("sim_dpram_asym: RATIO must be a power of two in 1..16 dividing DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [RW-1:0] rd_row;
  logic          row_hit;
  logic [RW-1:0] s1_data;
  logic          s1_valid;
  logic          s1_coll;

  function automatic logic [AW-1:0] lane_addr(input logic [RAW-1:0] row, input int k);
    return (AW'(row) << LB) | AW'(k);
  endfunction

  assign row_hit = we_i && (RAW'(waddr_i >> LB) == raddr_i);

  always_comb begin
    rd_row = '0;
    for (int k = 0; k < RATIO; k++) begin
      rd_row[k*WIDTH +: WIDTH] = mem[lane_addr(raddr_i, k)];
`ifdef SIM_DPRAM_ASYM_BYPASS_EN
      // write-first: only the lane being written sees the new word
      if (we_i && waddr_i == lane_addr(raddr_i, k))
        rd_row[k*WIDTH +: WIDTH] = wdata_i;
`endif
    end
  end

  // Array is deliberately not reset; unwritten words read as X.
  always_ff @(posedge clk) begin
    if (we_i && !sleep_i)
      mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else if (!sleep_i) begin
      s1_valid <= re_i;
      s1_coll  <= re_i && row_hit;
      if (re_i)
        s1_data <= rd_row;
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [RW-1:0] s2_data;
    logic          s2_valid;
    logic          s2_coll;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
      end else if (!sleep_i) begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        if (s1_valid)
          s2_data <= s1_data;
      end
    end

    assign rdata_o     = s2_data;
    assign rvalid_o    = s2_valid;
    assign collision_o = s2_coll;
  end else begin : g_lat1
    assign rdata_o     = s1_data;
    assign rvalid_o    = s1_valid;
    assign collision_o = s1_coll;
  end

endmodule

// File: tb/tb_sim_dpram_asym.sv
// tb/tb_sim_dpram_asym.sv - self-checking bench for sim_dpram_asym over three configurations
module tb_sim_dpram_asym;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance 0: W32 D256 R2 L1, instance 1: W8 D32 R4 L2, instance 2: W8 D16 R1 L1
  int W [3] = '{32, 8, 8};
  int D [3] = '{256, 32, 16};
  int R [3] = '{2, 4, 1};
  int L [3] = '{1, 2, 1};

  logic        dwe [3];
  logic [31:0] dwa [3];
  logic [31:0] dwd [3];
  logic        dre [3];
  logic [31:0] dra [3];
  logic        dsl [3];

  logic [63:0] rdata_a; logic rvalid_a, coll_a;
  logic [31:0] rdata_b; logic rvalid_b, coll_b;
  logic [7:0]  rdata_c; logic rvalid_c, coll_c;

  logic [63:0] obs_d [3];
  logic        obs_v [3];
  logic        obs_c [3];
  assign obs_d[0] = rdata_a;         assign obs_v[0] = rvalid_a; assign obs_c[0] = coll_a;
  assign obs_d[1] = 64'(rdata_b);    assign obs_v[1] = rvalid_b; assign obs_c[1] = coll_b;
  assign obs_d[2] = 64'(rdata_c);    assign obs_v[2] = rvalid_c; assign obs_c[2] = coll_c;

  sim_dpram_asym #(.WIDTH(32), .DEPTH(256), .RATIO(2), .LATENCY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .we_i(dwe[0]), .waddr_i(dwa[0][7:0]), .wdata_i(dwd[0]),
    .re_i(dre[0]), .raddr_i(dra[0][6:0]), .sleep_i(dsl[0]),
    .rdata_o(rdata_a), .rvalid_o(rvalid_a), .collision_o(coll_a));

  sim_dpram_asym #(.WIDTH(8), .DEPTH(32), .RATIO(4), .LATENCY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .we_i(dwe[1]), .waddr_i(dwa[1][4:0]), .wdata_i(dwd[1][7:0]),
    .re_i(dre[1]), .raddr_i(dra[1][2:0]), .sleep_i(dsl[1]),
    .rdata_o(rdata_b), .rvalid_o(rvalid_b), .collision_o(coll_b));

  sim_dpram_asym #(.WIDTH(8), .DEPTH(16), .RATIO(1), .LATENCY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .we_i(dwe[2]), .waddr_i(dwa[2][3:0]), .wdata_i(dwd[2][7:0]),
    .re_i(dre[2]), .raddr_i(dra[2][3:0]), .sleep_i(dsl[2]),
    .rdata_o(rdata_c), .rvalid_o(rvalid_c), .collision_o(coll_c));

  int checks = 0;
  int errors = 0;

  // reference: narrow word store plus a history of reads indexed by active-edge count
  logic [31:0] mm [3][256];
  int          act [3];
  logic        hv [3][4];
  logic [63:0] hd [3][4];
  logic        hc [3][4];
  logic [63:0] ld [3];

  task automatic expect_c(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 0;
      ld[i]  = '0;
      for (int j = 0; j < 4; j++) begin hv[i][j] = 1'b0; hd[i][j] = '0; hc[i][j] = 1'b0; end
    end
  endtask

  task automatic model_edge(input int i);
    logic [63:0] row, mask, word;
    int          a, e;
    if (dsl[i]) return;
    mask = (64'd1 << W[i]) - 64'd1;
    row  = '0;
    for (int k = 0; k < R[i]; k++) begin
      a    = int'(dra[i]) * R[i] + k;
      word = 64'(mm[i][a]) & mask;
`ifdef SIM_DPRAM_ASYM_BYPASS_EN
      if (dwe[i] && int'(dwa[i]) == a) word = 64'(dwd[i]) & mask;
`endif
      row = row | (word << (k * W[i]));
    end
    e = act[i] % 4;
    hv[i][e] = dre[i];
    hd[i][e] = row;
    hc[i][e] = dre[i] && dwe[i] && (int'(dwa[i]) / R[i] == int'(dra[i]));
    act[i]++;
    if (dwe[i]) mm[i][dwa[i]] = 32'(64'(dwd[i]) & mask);
    if (act[i] >= L[i] && hv[i][(act[i] - L[i]) % 4]) ld[i] = hd[i][(act[i] - L[i]) % 4];
  endtask

  task automatic chk(input int i);
    logic ev, ec;
    ev = 1'b0; ec = 1'b0;
    if (act[i] >= L[i]) begin
      ev = hv[i][(act[i] - L[i]) % 4];
      ec = ev && hc[i][(act[i] - L[i]) % 4];
    end
    expect_c($sformatf("rvalid[%0d]", i), 64'(obs_v[i]), 64'(ev));
    expect_c($sformatf("collision[%0d]", i), 64'(obs_c[i]), 64'(ec));
    expect_c($sformatf("rdata[%0d]", i), obs_d[i], ld[i]);
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      dwe[i] = 0; dwa[i] = 0; dwd[i] = 0; dre[i] = 0; dra[i] = 0; dsl[i] = 0;
    end
  endtask

  task automatic drv(input int i, input logic we, input int wa, input logic [31:0] wd,
                     input logic re, input int ra, input logic sl);
    dwe[i] = we; dwa[i] = wa; dwd[i] = wd; dre[i] = re; dra[i] = ra; dsl[i] = sl;
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i);
    #1;
    for (int i = 0; i < 3; i++) chk(i);
  endtask

  task automatic check_zero(input string tag);
    expect_c({tag, " rdata_a"}, rdata_a, 64'd0);
    expect_c({tag, " rvalid_b"}, 64'(rvalid_b), 64'd0);
    expect_c({tag, " coll_a"}, 64'(coll_a), 64'd0);
    expect_c({tag, " rdata_b"}, 64'(rdata_b), 64'd0);
    expect_c({tag, " rvalid_a"}, 64'(rvalid_a), 64'd0);
    expect_c({tag, " rdata_c"}, 64'(rdata_c), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #3;
    check_zero("reset");
    #20 rst_n = 1'b1;

    // fill every word so nothing reads X later
    for (int a = 0; a < 256; a++) begin
      idle();
      for (int i = 0; i < 3; i++)
        if (a < D[i]) drv(i, 1, a, $urandom, 0, 0, 0);
      step();
    end

    // narrow fill, wide read
    idle(); drv(0, 1, 0, 32'h11111111, 0, 0, 0); step();
    idle(); drv(0, 1, 1, 32'h22222222, 0, 0, 0); step();
    idle(); drv(0, 0, 0, 0, 1, 0, 0); step();
    expect_c("fill rdata", rdata_a, 64'h22222222_11111111);
    expect_c("fill rvalid", 64'(rvalid_a), 64'd1);
    idle(); step();
    expect_c("fill rvalid drop", 64'(rvalid_a), 64'd0);
    expect_c("fill rdata hold", rdata_a, 64'h22222222_11111111);

    // ratio 4, latency 2
    for (int k = 0; k < 4; k++) begin idle(); drv(1, 1, 4 + k, 32'hA0 + k, 0, 0, 0); step(); end
    idle(); drv(1, 0, 0, 0, 1, 1, 0); step();
    expect_c("lat2 t+1 rvalid", 64'(rvalid_b), 64'd0);
    idle(); step();
    expect_c("lat2 t+2 rvalid", 64'(rvalid_b), 64'd1);
    expect_c("lat2 t+2 rdata", 64'(rdata_b), 64'hA3A2A1A0);
    for (int r = 0; r < 3; r++) begin idle(); drv(1, 0, 0, 0, 1, (r == 1) ? 0 : 1, 0); step(); end
    idle(); step(); step(); step();

    // collision
    idle(); drv(0, 1, 0, 32'h1, 0, 0, 0); step();
    idle(); drv(0, 1, 1, 32'h2, 0, 0, 0); step();
    idle(); drv(0, 1, 1, 32'h9, 1, 0, 0); step();
    expect_c("coll flag", 64'(coll_a), 64'd1);
`ifdef SIM_DPRAM_ASYM_BYPASS_EN
    expect_c("coll data", rdata_a, 64'h00000009_00000001);
`else
    expect_c("coll data", rdata_a, 64'h00000002_00000001);
`endif
    idle(); drv(0, 0, 0, 0, 1, 0, 0); step();
    expect_c("coll after", rdata_a, 64'h00000009_00000001);
    expect_c("coll after flag", 64'(coll_a), 64'd0);

    // sleep with an in-flight latency-2 read
    idle(); drv(1, 0, 0, 0, 1, 1, 0); step();
    idle(); drv(1, 1, 4, 32'hFF, 1, 0, 1); step(); step();
    expect_c("sleep rvalid frozen", 64'(rvalid_b), 64'd0);
    idle(); step();
    expect_c("wake rvalid", 64'(rvalid_b), 64'd1);
    expect_c("wake rdata", 64'(rdata_b), 64'hA3A2A1A0);
    idle(); drv(1, 0, 0, 0, 1, 1, 0); step(); idle(); step();
    expect_c("sleep no write", 64'(rdata_b), 64'hA3A2A1A0);

    // ratio 1
    idle(); drv(2, 1, 15, 32'h5A, 0, 0, 0); step();
    idle(); drv(2, 0, 0, 0, 1, 15, 0); step();
    expect_c("r1 rdata", 64'(rdata_c), 64'h5A);
    expect_c("r1 rvalid", 64'(rvalid_c), 64'd1);

    // random traffic on all three, biased toward collisions
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        int wa;
        wa = int'($urandom_range(0, D[i] - 1));
        drv(i, 1'($urandom % 2), wa, $urandom, 1'(($urandom % 3) != 0),
            ($urandom % 2) ? wa / R[i] : int'($urandom_range(0, D[i] / R[i] - 1)),
            1'(($urandom % 10) == 0));
      end
      step();
    end

    // reset in the middle of streaming reads
    idle();
    for (int i = 0; i < 3; i++) drv(i, 0, 0, 0, 1, 0, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    @(posedge clk); @(posedge clk);
    #1 idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      expect_c("post reset rvalid_b", 64'(rvalid_b), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sim_dpram_asym.md
Name: sim_dpram_asym

Overview:
- Parametrised simple-dual-port simulation RAM: narrow write port (WIDTH bits), wide read port (RATIO*WIDTH bits).
- Single clock; 1- or 2-cycle registered read pipeline with a valid flag.
- Selectable read-during-write collision policy.
- Successor to the fixed 2:1 narrow-write/wide-read RAM; used for cache line fill buffers, where refill writes one word per beat and lookups read a full line.

Parameters:
- WIDTH, 32: narrow (write) word width in bits.
- DEPTH, 256: capacity in narrow words; must be a multiple of RATIO.
- RATIO, 2: wide/narrow ratio; power of two, 1..16. RATIO=1 degenerates to a plain equal-width RAM with no lane bits.
- LATENCY, 1: read latency in cycles, 1 or 2; any other value is a elaboration error.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- we_i, in, 1: write strobe.
- waddr_i, in, $clog2(DEPTH): narrow write address; row = waddr_i >> $clog2(RATIO), lane = low $clog2(RATIO) bits.
- wdata_i, in, WIDTH: write data.
- re_i, in, 1: read strobe.
- raddr_i, in, $clog2(DEPTH/RATIO): wide row address.
- sleep_i, in, 1: when 1, we_i and re_i are ignored and the pipeline holds.
- rdata_o, out, RATIO*WIDTH: wide read data; lane k occupies bits [k*WIDTH +: WIDTH], lane 0 at LSB.
- rvalid_o, out, 1: rdata_o carries the result of a read issued LATENCY cycles earlier.
- collision_o, out, 1: one-cycle pulse aligned with rvalid_o; marks that the read row was written in its issue cycle.

Behaviour:
- Reset (rst_n low, asynchronous): rdata_o = 0, rvalid_o = 0, collision_o = 0; all pipeline stages cleared.
  - Memory array is not reset; its contents are X until written.
  - Reset asserted mid-read drops that read; no rvalid_o pulse appears after release.
- Write: at edge t with we_i=1 and sleep_i=0, ram[row][lane] <= wdata_i. Other lanes of the row are unchanged.
- Read, stage 1: at edge t with re_i=1 and sleep_i=0, the full row raddr_i is captured into the stage-1 data register, s1_valid <= 1, s1_coll <= (we_i && row(waddr_i)==raddr_i).
  - If re_i=0 at edge t: s1_valid <= 0 and the stage-1 data register holds.
- LATENCY=1: rdata_o/rvalid_o/collision_o are the stage-1 registers. Data is visible after edge t.
- LATENCY=2: a second register stage copies stage 1 at edge t+1. rdata_o updates only when stage-1 valid=1; otherwise it holds its previous value. rvalid_o follows s1_valid delayed by one cycle.
- rdata_o always holds the last returned value while rvalid_o=0; it never returns to 0 except on reset.
- Back-to-back reads every cycle are supported: throughput is 1 row/cycle at either LATENCY.
- sleep_i=1 at an edge: no write; no stage advances; all outputs hold their values (rvalid_o included).
- Collision (same-cycle write and read of the same row): data policy is set by the optional feature.
  - collision_o is raised regardless of policy.
  - Lanes of the row not being written always return stored data.
- Address wrap: no wrap logic. waddr_i and raddr_i span exactly the array. An illegal DEPTH/RATIO combination fails at elaboration.

Optional Feature:
- Macro: SIM_DPRAM_ASYM_BYPASS_EN.
- Defined (write-first): on collision, the written lane of the captured row takes wdata_i. The read returns the new word plus the stored other lanes.
- Undefined (read-first): on collision, the captured row is the pre-write contents. The new word is visible to reads issued at t+1 or later.
- collision_o behaves identically in both builds.

Test Plan:
- Reset: rst_n=0 mid-stream with re_i=1 -> rdata_o=0, rvalid_o=0, collision_o=0 immediately. No valid pulse in the 3 cycles after release.
- Narrow fill/wide read (WIDTH=32, RATIO=2, LATENCY=1): write 0x11111111 @0, 0x22222222 @1, then read row 0 -> next cycle rdata_o=0x2222222211111111, rvalid_o=1 for one cycle.
- RATIO=4, LATENCY=2: write 0xA0..0xA3 to narrow addresses 4..7, read row 1 at cycle t.
  - rvalid_o=1 exactly at t+2 with rdata_o = {0xA3,0xA2,0xA1,0xA0}.
  - Reads at rows 1,0,1 on consecutive cycles return in order with rvalid_o high for 3 cycles.
- Collision: row 0 holds {0x2,0x1}; same edge write 0x9 @ narrow address 1 and read row 0.
  - With SIM_DPRAM_ASYM_BYPASS_EN: {0x9,0x1}. Without: {0x2,0x1}.
  - collision_o=1 in both builds. A read of row 0 one cycle later returns {0x9,0x1}.
- Sleep: assert sleep_i with we_i=1 and re_i=1 for 2 cycles.
  - No memory change (later read returns old data).
  - rdata_o and rvalid_o frozen. An in-flight LATENCY=2 read completes 1 cycle after sleep_i drops.
- RATIO=1 degenerate: DEPTH=16, write 0x5A @ address 15, read address 15 -> rdata_o=0x5A, rvalid_o=1 after 1 cycle.
